// File: rtl/mult_div_pkg.sv
// Shared types for the iterative multiply/divide unit: op encodings, FSM states, default width.
// Signed MULT/DIV support is enabled by defining MULT_DIV_SIGNED_EN.
package mult_div_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

endpackage

// File: rtl/mult_div_core.sv
// Datapath for the multiply/divide unit: one 2*W accumulator shared by shift-add multiply
// and restoring divide. Operands arrive as magnitudes; sign handling lives in the top.
module mult_div_core #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      load,
   input  logic                      step,
   input  logic                      is_div,
   input  logic [DATA_WIDTH-1:0]     a_mag,
   input  logic [DATA_WIDTH-1:0]     b_mag,
   output logic [2*DATA_WIDTH-1:0]   acc
);

   logic [DATA_WIDTH-1:0]   operand_b;
   logic                    div_mode;
   logic [DATA_WIDTH:0]     add_sum;
   logic [DATA_WIDTH:0]     trial;
   logic [2*DATA_WIDTH-1:0] next_acc;

   // Multiply: upper half accumulates, low half holds the shrinking multiplier.
   // Divide: upper half is the partial remainder, quotient bits enter at the bottom;
   // the remainder invariant (< divisor) keeps trial's MSB a clean borrow flag.
   always_comb begin
      add_sum  = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} +
                 (acc[0] ? {1'b0, operand_b} : {(DATA_WIDTH+1){1'b0}});
      trial    = acc[2*DATA_WIDTH-1:DATA_WIDTH-1] - {1'b0, operand_b};
      next_acc = {add_sum, acc[DATA_WIDTH-1:1]};
      if (div_mode) begin
         if (!trial[DATA_WIDTH]) begin
            next_acc = {trial[DATA_WIDTH-1:0], acc[DATA_WIDTH-2:0], 1'b1};
         end else begin
            next_acc = {acc[2*DATA_WIDTH-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc       <= '0;
         operand_b <= '0;
         div_mode  <= 1'b0;
      end else if (load) begin
         acc       <= {{DATA_WIDTH{1'b0}}, a_mag};
         operand_b <= b_mag;
         div_mode  <= is_div;
      end else if (step) begin
         acc       <= next_acc;
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing HI/LO after DATA_WIDTH+2 enabled cycles.
// Define MULT_DIV_SIGNED_EN to let op[0] select signed operation; otherwise all ops are unsigned.
module mult_div_unit
   import mult_div_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clkEnable,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] opA,
   input  logic [DATA_WIDTH-1:0] opB,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo,
   output logic                  divByZero
);

   localparam int CW = $clog2(DATA_WIDTH);

   state_t                  state, next_state;
   logic [CW-1:0]           count;
   logic                    accept, is_div, op_div, b_zero;
   logic [DATA_WIDTH-1:0]   a_raw, a_mag, b_mag;
   logic [2*DATA_WIDTH-1:0] acc, prod_fixed;
   logic [DATA_WIDTH-1:0]   quot_fixed, rem_fixed;

   assign accept = start && clkEnable && (state == IDLE || state == DONE);
   assign is_div = (op_t'(op) == OP_DIVU) || (op_t'(op) == OP_DIV);

`ifdef MULT_DIV_SIGNED_EN
   logic sign_a, sign_b, neg_result, neg_rem;

   // The core works on magnitudes; remember which results must be negated at FIX.
   assign sign_a     = op[0] & opA[DATA_WIDTH-1];
   assign sign_b     = op[0] & opB[DATA_WIDTH-1];
   assign a_mag      = sign_a ? -opA : opA;
   assign b_mag      = sign_b ? -opB : opB;
   assign prod_fixed = neg_result ? -acc : acc;
   assign quot_fixed = neg_result ? -acc[DATA_WIDTH-1:0] : acc[DATA_WIDTH-1:0];
   assign rem_fixed  = neg_rem ? -acc[2*DATA_WIDTH-1:DATA_WIDTH] : acc[2*DATA_WIDTH-1:DATA_WIDTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         neg_result <= 1'b0;
         neg_rem    <= 1'b0;
      end else if (accept) begin
         neg_result <= sign_a ^ sign_b;
         neg_rem    <= sign_a;
      end
   end
`else
   assign a_mag      = opA;
   assign b_mag      = opB;
   assign prod_fixed = acc;
   assign quot_fixed = acc[DATA_WIDTH-1:0];
   assign rem_fixed  = acc[2*DATA_WIDTH-1:DATA_WIDTH];
`endif

   mult_div_core #(.DATA_WIDTH(DATA_WIDTH)) core (
      .clk    (clk),
      .reset  (reset),
      .load   (accept),
      .step   (state == CALC && clkEnable),
      .is_div (is_div),
      .a_mag  (a_mag),
      .b_mag  (b_mag),
      .acc    (acc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (accept) next_state = CALC;
         CALC: if (clkEnable && count == CW'(DATA_WIDTH-1)) next_state = FIX;
         FIX:  if (clkEnable) next_state = DONE;
         DONE: begin
            if (accept) next_state = CALC;
            else if (clkEnable) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == CALC) || (state == FIX);
      done = (state == DONE);
   end

   // hi/lo change only at FIX; a zero divisor bypasses sign correction entirely.
   always_ff @(posedge clk) begin
      if (reset) begin
         count     <= '0;
         op_div    <= 1'b0;
         b_zero    <= 1'b0;
         a_raw     <= '0;
         hi        <= '0;
         lo        <= '0;
         divByZero <= 1'b0;
      end else if (accept) begin
         count     <= '0;
         op_div    <= is_div;
         b_zero    <= (opB == '0);
         a_raw     <= opA;
         divByZero <= 1'b0;
      end else if (clkEnable) begin
         if (state == CALC) begin
            count <= count + 1'b1;
         end else if (state == FIX) begin
            if (op_div && b_zero) begin
               hi        <= a_raw;
               lo        <= '1;
               divByZero <= 1'b1;
            end else if (op_div) begin
               hi <= rem_fixed;
               lo <= quot_fixed;
            end else begin
               {hi, lo} <= prod_fixed;
            end
         end
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: driver pushes model results, a negedge monitor checks done beats.
// Follows MULT_DIV_SIGNED_EN the same way as the design build.
module tb_mult_div_unit;

   localparam int W   = 32;
   localparam int LAT = W + 1;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      int           cycle;
      string        name;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset, clkEnable, start;
   logic [1:0]   op;
   logic [W-1:0] opA, opB;
   logic         busy, done, divByZero;
   logic [W-1:0] hi, lo;

   exp_t         scoreboard[$];
   exp_t         monItem;
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   logic [W-1:0] lastHi = '0;
   logic [W-1:0] lastLo = '0;

   mult_div_unit dut (
      .clk       (clk),
      .reset     (reset),
      .clkEnable (clkEnable),
      .start     (start),
      .op        (op),
      .opA       (opA),
      .opB       (opB),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo),
      .divByZero (divByZero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference results straight from integer arithmetic (truncating division, MIPS style).
   function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t   e;
      logic   sgn;
      longint sa, sbv, p, q, r;
`ifdef MULT_DIV_SIGNED_EN
      sgn = o[0];
`else
      sgn = 1'b0;
`endif
      sa    = sgn ? longint'($signed(a)) : longint'(a);
      sbv   = sgn ? longint'($signed(b)) : longint'(b);
      e.dbz = 1'b0;
      if (!o[1]) begin
         p    = sa * sbv;
         e.hi = p[63:32];
         e.lo = p[31:0];
      end else if (b == '0) begin
         e.hi  = a;
         e.lo  = '1;
         e.dbz = 1'b1;
      end else begin
         q    = sa / sbv;
         r    = sa % sbv;
         e.hi = r[31:0];
         e.lo = q[31:0];
      end
      e.cycle = 0;
      e.name  = "";
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Monitor: every enabled done beat must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && done && clkEnable) begin
         if (scoreboard.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedDone: got done at cycle %0d expected none", cyc);
         end else begin
            monItem = scoreboard.pop_front();
            checkOutput({monItem.name, ".hi"}, hi, monItem.hi);
            checkOutput({monItem.name, ".lo"}, lo, monItem.lo);
            checkOutput({monItem.name, ".divByZero"}, W'(divByZero), W'(monItem.dbz));
            checkOutput({monItem.name, ".busyAtDone"}, W'(busy), '0);
            checkOutput({monItem.name, ".doneCycle"}, cyc, monItem.cycle);
            lastHi = monItem.hi;
            lastLo = monItem.lo;
         end
      end
   end

   task automatic waitIdle(input string name);
      int n = 0;
      while (scoreboard.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (scoreboard.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s.timeout: got %0d pending results expected 0", name, scoreboard.size());
         scoreboard.delete();
      end
   endtask

   // Issue one operation; optionally stall clkEnable mid-CALC or poke start while busy.
   task automatic applyStimulus(input string name, input logic [1:0] o, input logic [W-1:0] a,
                                input logic [W-1:0] b, input int stallLen, input bit pokeStart,
                                input bit doExpect);
      exp_t e;
      waitIdle(name);
      @(posedge clk); #1;
      start = 1'b1; op = o; opA = a; opB = b;
      @(posedge clk); #1;
      start = 1'b0; opA = $urandom; opB = $urandom; op = 2'($urandom);
      if (doExpect) begin
         e       = model(o, a, b);
         e.cycle = cyc + LAT + stallLen;
         e.name  = name;
         scoreboard.push_back(e);
      end
      checkOutput({name, ".busyAfterStart"}, W'(busy), W'(1));
      checkOutput({name, ".divByZeroCleared"}, W'(divByZero), '0);
      if (pokeStart) begin
         repeat (8) @(posedge clk);
         #1 start = 1'b1; opA = $urandom; opB = 32'd3;
         @(posedge clk); #1 start = 1'b0;
      end
      if (stallLen > 0) begin
         repeat (9) @(posedge clk);
         #1 clkEnable = 1'b0;
         checkOutput({name, ".hiHeld"}, hi, lastHi);
         checkOutput({name, ".loHeld"}, lo, lastLo);
         repeat (stallLen) @(posedge clk);
         #1 clkEnable = 1'b1;
      end
   endtask

   initial begin
      exp_t e;
      int   n;
      reset = 1'b1; clkEnable = 1'b1; start = 1'b0; op = 2'b00; opA = '0; opB = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      checkOutput("reset.busy", W'(busy), '0);
      checkOutput("reset.done", W'(done), '0);
      checkOutput("reset.hi", hi, '0);
      checkOutput("reset.lo", lo, '0);
      checkOutput("reset.divByZero", W'(divByZero), '0);

      applyStimulus("multuMax", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, 1'b1);
      applyStimulus("multNeg", 2'b01, 32'hFFFFFFFD, 32'd7, 0, 1'b0, 1'b1);
      applyStimulus("divNeg", 2'b11, 32'hFFFFFFF9, 32'd2, 0, 1'b0, 1'b1);
      applyStimulus("divu100by7", 2'b10, 32'd100, 32'd7, 0, 1'b0, 1'b1);
      applyStimulus("divuByZero", 2'b10, 32'd5, 32'd0, 0, 1'b0, 1'b1);
      applyStimulus("afterDivZero", 2'b00, 32'd12345, 32'd678, 0, 1'b0, 1'b1);
      applyStimulus("divOverflow", 2'b11, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0, 1'b1);
      applyStimulus("ignoredStart", 2'b10, 32'hDEADBEEF, 32'd13, 0, 1'b1, 1'b1);
      applyStimulus("stall5", 2'b01, 32'h12345678, 32'h9ABCDEF0, 5, 1'b0, 1'b1);

      // Back-to-back: start presented during the done cycle is accepted at once.
      applyStimulus("backToBack1", 2'b00, 32'd1000, 32'd2000, 0, 1'b0, 1'b1);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!done && n < 100);
      start = 1'b1; op = 2'b10; opA = 32'd999; opB = 32'd10;
      @(posedge clk); #1;
      start = 1'b0; opA = $urandom; opB = $urandom;
      e       = model(2'b10, 32'd999, 32'd10);
      e.cycle = cyc + LAT;
      e.name  = "backToBack2";
      scoreboard.push_back(e);
      waitIdle("backToBack2");

      // Reset in the middle of an operation: no result, outputs return to reset values.
      applyStimulus("resetMid", 2'b00, 32'hFFFF0000, 32'h0000FFFF, 0, 1'b0, 1'b0);
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      checkOutput("resetMid.busy", W'(busy), '0);
      checkOutput("resetMid.done", W'(done), '0);
      checkOutput("resetMid.hi", hi, '0);
      checkOutput("resetMid.lo", lo, '0);
      lastHi = '0;
      lastLo = '0;
      repeat (45) @(posedge clk);

      for (int i = 0; i < 14; i++) begin
         logic [1:0]   ro;
         logic [W-1:0] ra, rb;
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         if (i % 5 == 2) rb = '0;
         if (i % 5 == 3) rb = 32'($urandom_range(1, 20));
         if (i % 7 == 4) ra = 32'h80000000;
         applyStimulus($sformatf("random%0d", i), ro, ra, rb, (i % 4 == 1) ? int'($urandom_range(1, 4)) : 0,
                       1'b0, 1'b1);
      end

      waitIdle("final");
      repeat (5) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the MIPS execute stage, directly downstream of the register bank. Consumes the two register-read operands (rs on regA, rt on regB) for MULT/MULTU/DIV/DIVU and produces the HI/LO pair after a fixed multi-cycle latency. The pipeline controller uses a start/busy/done handshake to stall MFHI/MFLO until the results are valid.

## Interface
- DATA_WIDTH, 32, operand and HI/LO width; iteration count equals DATA_WIDTH
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- clkEnable  in  1  global step enable; when low, no state changes (same gating as the register bank)
- start  in  1  request a new operation; sampled only in IDLE or DONE
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- opA  in  DATA_WIDTH  rs operand (multiplicand / dividend), from register bank regA
- opB  in  DATA_WIDTH  rt operand (multiplier / divisor), from register bank regB
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse; hi/lo valid from this cycle on
- hi  out  DATA_WIDTH  product[63:32] or remainder
- lo  out  DATA_WIDTH  product[31:0] or quotient
- divByZero  out  1  set with done when a divide had opB == 0; held until next accepted start

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE/DONE + start & clkEnable: latch op, operand magnitudes (sign bits for signed ops), clear counter -> CALC; clear divByZero.
- CALC: one shift-add (multiply) or restoring-subtract (divide) step per enabled cycle; counter 0..DATA_WIDTH-1; after the step with counter == DATA_WIDTH-1 -> FIX.
- FIX: apply sign correction, write hi/lo, set divByZero if applicable -> DONE.
- DONE: done = 1 for one cycle; -> IDLE unless start is accepted (back-to-back allowed -> CALC).
- start in CALC or FIX is ignored; no queueing.
- Multiply: 2*DATA_WIDTH-bit accumulator; signed result = two's-complement negation of the magnitude product when operand signs differ.
- Divide: quotient negated when signs differ; remainder takes the dividend's sign.
- opB == 0 (DIV/DIVU): hi = opA, lo = all ones, divByZero = 1; sign fix bypassed; latency unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (magnitude result, no negation).
- hi/lo hold their value until the next FIX; they are not modified while busy.

## Timing
- Reset values: busy 0, done 0, divByZero 0, hi 0, lo 0, state IDLE.
- start accepted at edge E (clkEnable high): busy = 1 from E through E+DATA_WIDTH+1; FIX at edge E+DATA_WIDTH+1; done = 1 and busy = 0 during the cycle after edge E+DATA_WIDTH+1 (34 cycles for DATA_WIDTH = 32).
- clkEnable low stretches latency cycle for cycle; the done pulse lasts one enabled cycle.
- Reset mid-operation: aborts at that edge; all outputs return to reset values; no done pulse.
- Operands are sampled only at acceptance; later changes on opA/opB have no effect.

## Configuration
- MULT_DIV_SIGNED_EN defined: op[0] selects signed MULT/DIV as described above.
- Not defined: op[0] ignored; all operations unsigned; sign-fix logic removed; FIX only registers results (latency unchanged).

## Structure
- Package mult_div_pkg: op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV), FSM state type, DATA_WIDTH default.
- One sub-module, mult_div_core: accumulator/remainder shift registers and single-step add/subtract; FSM, counter, and sign handling stay in mult_div_unit.

## Test plan
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 34 cycles: hi 0xFFFFFFFE, lo 0x00000001, done pulse for exactly one cycle.
- MULT -3 x 7 -> hi 0xFFFFFFFF, lo 0xFFFFFFEB; the same with MULT_DIV_SIGNED_EN undefined -> hi 0x00000006, lo 0xFFFFFFEB.
- DIV -7 / 2 -> lo 0xFFFFFFFD, hi 0xFFFFFFFF; DIVU 100 / 7 -> lo 14, hi 2.
- DIVU 5 / 0 -> hi 5, lo 0xFFFFFFFF, divByZero 1; the next start clears divByZero.
- start pulsed during CALC is ignored; start in the DONE cycle is accepted and yields a second done exactly 34 cycles later.
- Reset asserted at cycle 10 of an operation -> next cycle busy 0, hi/lo 0, no done; clkEnable held low for 5 cycles mid-operation -> done delayed by exactly 5 cycles.
